// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the N-row line buffer and its RAM banks.
package line_buffer_pkg;

  localparam int unsigned PIX_W_DEFAULT = 1;
  localparam logic        PAD_BIT       = 1'b0;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_bank.sv
// One line of pixel storage: simple dual-port RAM with a registered read port.
module line_bank #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 1920,
  parameter int AW     = 11
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array left unreset so it maps onto block RAM; same-address read returns old data.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_buffer_nrow.sv
// N-row line buffer: one raster pixel in, one vertical NUM_ROWS-pixel column out, 1-cycle latency.
module line_buffer_nrow
  import line_buffer_pkg::*;
#(
  parameter int DATA_W    = PIX_W_DEFAULT,
  parameter int MAX_WIDTH = 1920,
  parameter int NUM_ROWS  = 3,
  parameter int ADDR_W    = 12
) (
  input  logic                         clka,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            line_len,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  output logic [NUM_ROWS*DATA_W-1:0]   out_col,
  output logic [ADDR_W-1:0]            out_x,
  output logic                         out_y_ok
);

  localparam int NB = NUM_ROWS - 1;
  localparam int BW = (NB > 1) ? clog2(NB) : 1;
  localparam int FW = clog2(NB + 1);
  localparam int LW = ADDR_W + 1;
  localparam int IW = (clog2(MAX_WIDTH) > 0) ? clog2(MAX_WIDTH) : 1;
  localparam logic [LW-1:0] MAXW = LW'(MAX_WIDTH);

  logic [ADDR_W-1:0] r_x;
  logic [LW-1:0]     r_len;
  logic [BW-1:0]     r_rot;
  logic [FW-1:0]     r_fill;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_x;
  logic              r_y_ok;
  logic [DATA_W-1:0] r_cur;
  logic [BW-1:0]     r_sel_rot;
  logic [FW-1:0]     r_sel_fill;

  logic [LW-1:0]     w_len_in, w_len_clamp, w_len;
  logic [ADDR_W-1:0] w_x;
  logic [BW-1:0]     w_rot, w_rot_nxt;
  logic [FW-1:0]     w_fill, w_fill_nxt;
  logic              w_wrap, w_acc;
  logic [NB-1:0]     w_we;
  logic [DATA_W-1:0] w_rd [NB];
  logic [NUM_ROWS*DATA_W-1:0] w_col;

  // Start of frame overrides the running position so its pixel lands at row 0, column 0.
  assign w_len_in    = {1'b0, line_len};
  assign w_len_clamp = (line_len == '0 || w_len_in > MAXW) ? MAXW : w_len_in;
  assign w_x         = in_sof ? '0 : r_x;
  assign w_rot       = in_sof ? '0 : r_rot;
  assign w_fill      = in_sof ? '0 : r_fill;
  assign w_len       = in_sof ? w_len_clamp : r_len;
  assign w_wrap      = ({1'b0, w_x} == (w_len - LW'(1)));
  assign w_rot_nxt   = (w_rot == BW'(NB - 1)) ? '0 : w_rot + BW'(1);
  assign w_fill_nxt  = (w_fill == FW'(NB)) ? w_fill : w_fill + FW'(1);
  assign w_acc       = in_valid && !rst;

  always_ff @(posedge clka) begin
    if (rst) begin
      r_x         <= '0;
      r_len       <= MAXW;
      r_rot       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_y_ok      <= 1'b0;
      r_cur       <= '0;
      r_sel_rot   <= '0;
      r_sel_fill  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_len <= w_len;
        if (w_wrap) begin
          r_x    <= '0;
          r_rot  <= w_rot_nxt;
          r_fill <= w_fill_nxt;
        end else begin
          r_x    <= w_x + ADDR_W'(1);
          r_rot  <= w_rot;
          r_fill <= w_fill;
        end
        r_out_x    <= w_x;
        r_y_ok     <= (w_fill == FW'(NB));
        r_cur      <= in_data;
        r_sel_rot  <= w_rot;
        r_sel_fill <= w_fill;
      end
    end
  end

  // The write target is always the oldest line, i.e. the bank at the rotation index.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign w_we[b] = w_acc && (w_rot == BW'(b));
    line_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_WIDTH),
      .AW     (IW)
    ) u_bank (
      .i_clk   (clka),
      .i_we    (w_we[b]),
      .i_waddr (w_x[IW-1:0]),
      .i_wdata (in_data),
      .i_re    (w_acc),
      .i_raddr (w_x[IW-1:0]),
      .o_rdata (w_rd[b])
    );
  end

  function automatic int bank_of(input logic [BW-1:0] rot, input int k);
    return (int'(rot) + NB - k) % NB;
  endfunction

  always_comb begin
    w_col = '0;
    w_col[DATA_W-1:0] = r_cur;
    for (int k = 1; k < NUM_ROWS; k++) begin
      w_col[k*DATA_W +: DATA_W] = {DATA_W{PAD_BIT}};
      for (int b = 0; b < NB; b++) begin
        if (int'(r_sel_fill) >= k && bank_of(r_sel_rot, k) == b)
          w_col[k*DATA_W +: DATA_W] = w_rd[b];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_col   = w_col;
  assign out_x     = r_out_x;
  assign out_y_ok  = r_y_ok;

endmodule
